tl_ul_arb2: RTL and testbench

// - Two-master TileLink-UL arbiter: shares one 32-bit slave port between two requesters (e.g. core data port, debug SBA).
// - Sits upstream of the TL pass-through buffer stage on the slave side.
// - A channel: round-robin arbitration with the grant held while stalled.
// - D channel: steers each response back to its requester using a master-index bit prepended to source.
// - Tracks outstanding transactions per master and throttles requests at the limit.

---
 rtl/tl_ul_pkg.sv | 29 ++
 rtl/tl_outstanding_ctr.sv | 22 ++
 rtl/tl_ul_arb2.sv | 124 ++++++++++++
 tb/tb_tl_ul_arb2.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: shared TileLink-UL constants and channel structs
package tl_ul_pkg;
  localparam int TL_SIZE_W = 2;
  localparam int TL_SRC_W = 2;
  localparam int CNT_W = 4;
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET = 3'd4;
  localparam logic [2:0] OP_ACK = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;
  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] param;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W:0] source;
    logic [31:0] address;
    logic [3:0] mask;
    logic [31:0] data;
  } tl_a_t;
  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] param;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W:0] source;
    logic denied;
    logic corrupt;
    logic [31:0] data;
  } tl_d_t;
endpackage

// File: rtl/tl_outstanding_ctr.sv
// tl_outstanding_ctr: saturating up/down outstanding-transaction counter
module tl_outstanding_ctr
  import tl_ul_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic [CNT_W-1:0] cnt,
  output logic full,
  output logic empty
);
  assign full = cnt == CNT_W'(MAX);
  assign empty = cnt == '0;
  always_ff @(posedge clock) begin
    if (reset) cnt <= '0;
    else if (inc && !dec && !full) cnt <= cnt + CNT_W'(1);
    else if (dec && !inc && !empty) cnt <= cnt - CNT_W'(1);
  end
endmodule

// File: rtl/tl_ul_arb2.sv
// tl_ul_arb2: two-master TileLink-UL arbiter, round-robin A with stall lock, D steered by source MSB
module tl_ul_arb2
  import tl_ul_pkg::*;
#(
  parameter int SRC_W = 2,
  parameter int SIZE_W = TL_SIZE_W,
  parameter int MAX_OUT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in0_a_valid,
  output logic              in0_a_ready,
  input  logic [2:0]        in0_a_opcode,
  input  logic [2:0]        in0_a_param,
  input  logic [SIZE_W-1:0] in0_a_size,
  input  logic [SRC_W-1:0]  in0_a_source,
  input  logic [31:0]       in0_a_address,
  input  logic [3:0]        in0_a_mask,
  input  logic [31:0]       in0_a_data,
  output logic              in0_d_valid,
  input  logic              in0_d_ready,
  output logic [2:0]        in0_d_opcode,
  output logic [1:0]        in0_d_param,
  output logic [SIZE_W-1:0] in0_d_size,
  output logic [SRC_W-1:0]  in0_d_source,
  output logic              in0_d_denied,
  output logic              in0_d_corrupt,
  output logic [31:0]       in0_d_data,
  input  logic              in1_a_valid,
  output logic              in1_a_ready,
  input  logic [2:0]        in1_a_opcode,
  input  logic [2:0]        in1_a_param,
  input  logic [SIZE_W-1:0] in1_a_size,
  input  logic [SRC_W-1:0]  in1_a_source,
  input  logic [31:0]       in1_a_address,
  input  logic [3:0]        in1_a_mask,
  input  logic [31:0]       in1_a_data,
  output logic              in1_d_valid,
  input  logic              in1_d_ready,
  output logic [2:0]        in1_d_opcode,
  output logic [1:0]        in1_d_param,
  output logic [SIZE_W-1:0] in1_d_size,
  output logic [SRC_W-1:0]  in1_d_source,
  output logic              in1_d_denied,
  output logic              in1_d_corrupt,
  output logic [31:0]       in1_d_data,
  output logic              out_a_valid,
  input  logic              out_a_ready,
  output logic [2:0]        out_a_opcode,
  output logic [2:0]        out_a_param,
  output logic [SIZE_W-1:0] out_a_size,
  output logic [SRC_W:0]    out_a_source,
  output logic [31:0]       out_a_address,
  output logic [3:0]        out_a_mask,
  output logic [31:0]       out_a_data,
  input  logic              out_d_valid,
  output logic              out_d_ready,
  input  logic [2:0]        out_d_opcode,
  input  logic [1:0]        out_d_param,
  input  logic [SIZE_W-1:0] out_d_size,
  input  logic [SRC_W:0]    out_d_source,
  input  logic              out_d_denied,
  input  logic              out_d_corrupt,
  input  logic [31:0]       out_d_data
);
  logic lock, lock_idx, rr_ptr, grant, req, a_fire, d_fire, d_idx;
  logic elig0, elig1, full0, full1, empty0, empty1, inc0, inc1, dec0, dec1;
  logic [CNT_W-1:0] cnt0, cnt1;
  assign elig0 = in0_a_valid && !full0;
  assign elig1 = in1_a_valid && !full1;
  // A locked master stays granted even if it has since reached the limit
  assign grant = lock ? lock_idx : (elig0 && elig1) ? rr_ptr : elig1;
  assign req = lock ? (lock_idx ? in1_a_valid : in0_a_valid) : (elig0 || elig1);
  assign out_a_valid = !reset && req;
  assign a_fire = out_a_valid && out_a_ready;
  assign in0_a_ready = a_fire && !grant;
  assign in1_a_ready = a_fire && grant;
  assign out_a_opcode = grant ? in1_a_opcode : in0_a_opcode;
  assign out_a_param = grant ? in1_a_param : in0_a_param;
  assign out_a_size = grant ? in1_a_size : in0_a_size;
  assign out_a_source = {grant, grant ? in1_a_source : in0_a_source};
  assign out_a_address = grant ? in1_a_address : in0_a_address;
  assign out_a_mask = grant ? in1_a_mask : in0_a_mask;
  assign out_a_data = grant ? in1_a_data : in0_a_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      lock <= 1'b0;
      lock_idx <= 1'b0;
      rr_ptr <= 1'b0;
    end else if (a_fire) begin
      lock <= 1'b0;
      rr_ptr <= ~grant;
    end else if (out_a_valid) begin
      lock <= 1'b1;
      lock_idx <= grant;
    end
  end
  assign d_idx = out_d_source[SRC_W];
  assign in0_d_valid = !reset && out_d_valid && !d_idx;
  assign in1_d_valid = !reset && out_d_valid && d_idx;
  assign out_d_ready = !reset && (d_idx ? in1_d_ready : in0_d_ready);
  assign d_fire = out_d_valid && out_d_ready;
  assign {in0_d_opcode, in1_d_opcode} = {2{out_d_opcode}};
  assign {in0_d_param, in1_d_param} = {2{out_d_param}};
  assign {in0_d_size, in1_d_size} = {2{out_d_size}};
  assign {in0_d_source, in1_d_source} = {2{out_d_source[SRC_W-1:0]}};
  assign {in0_d_denied, in1_d_denied} = {2{out_d_denied}};
  assign {in0_d_corrupt, in1_d_corrupt} = {2{out_d_corrupt}};
  assign {in0_d_data, in1_d_data} = {2{out_d_data}};
  assign inc0 = in0_a_ready;
  assign inc1 = in1_a_ready;
  assign dec0 = d_fire && !d_idx;
  assign dec1 = d_fire && d_idx;
  tl_outstanding_ctr #(.MAX(MAX_OUT)) u_ctr0 (
    .clock(clock), .reset(reset), .inc(inc0), .dec(dec0), .cnt(cnt0), .full(full0), .empty(empty0)
  );
  tl_outstanding_ctr #(.MAX(MAX_OUT)) u_ctr1 (
    .clock(clock), .reset(reset), .inc(inc1), .dec(dec1), .cnt(cnt1), .full(full1), .empty(empty1)
  );
  a_d_idle0: assert property (@(posedge clock) disable iff (reset) !(dec0 && !inc0 && empty0))
    else $error("response to master 0 with nothing outstanding");
  a_d_idle1: assert property (@(posedge clock) disable iff (reset) !(dec1 && !inc1 && empty1))
    else $error("response to master 1 with nothing outstanding");
endmodule

// File: tb/tb_tl_ul_arb2.sv
// tb_tl_ul_arb2: directed vectors for the two-master TL-UL arbiter
module tb_tl_ul_arb2;
  import tl_ul_pkg::*;
  logic clk = 1'b0, reset;
  logic in0_a_valid, in0_a_ready, in1_a_valid, in1_a_ready;
  logic [2:0] in0_a_opcode, in0_a_param, in1_a_opcode, in1_a_param;
  logic [1:0] in0_a_size, in1_a_size, in0_a_source, in1_a_source;
  logic [31:0] in0_a_address, in1_a_address, in0_a_data, in1_a_data;
  logic [3:0] in0_a_mask, in1_a_mask;
  logic in0_d_valid, in0_d_ready, in1_d_valid, in1_d_ready;
  logic [2:0] in0_d_opcode, in1_d_opcode;
  logic [1:0] in0_d_param, in1_d_param, in0_d_size, in1_d_size, in0_d_source, in1_d_source;
  logic in0_d_denied, in1_d_denied, in0_d_corrupt, in1_d_corrupt;
  logic [31:0] in0_d_data, in1_d_data;
  logic out_a_valid, out_a_ready;
  logic [2:0] out_a_opcode, out_a_param, out_a_source;
  logic [1:0] out_a_size;
  logic [31:0] out_a_address, out_a_data;
  logic [3:0] out_a_mask;
  logic out_d_valid, out_d_ready, out_d_denied, out_d_corrupt;
  logic [2:0] out_d_opcode, out_d_source;
  logic [1:0] out_d_param, out_d_size;
  logic [31:0] out_d_data;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  tl_ul_arb2 #(.SRC_W(2), .SIZE_W(2), .MAX_OUT(4)) dut (
    .clock(clk), .reset(reset),
    .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_opcode(in0_a_opcode),
    .in0_a_param(in0_a_param), .in0_a_size(in0_a_size), .in0_a_source(in0_a_source),
    .in0_a_address(in0_a_address), .in0_a_mask(in0_a_mask), .in0_a_data(in0_a_data),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_opcode(in0_d_opcode),
    .in0_d_param(in0_d_param), .in0_d_size(in0_d_size), .in0_d_source(in0_d_source),
    .in0_d_denied(in0_d_denied), .in0_d_corrupt(in0_d_corrupt), .in0_d_data(in0_d_data),
    .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_opcode(in1_a_opcode),
    .in1_a_param(in1_a_param), .in1_a_size(in1_a_size), .in1_a_source(in1_a_source),
    .in1_a_address(in1_a_address), .in1_a_mask(in1_a_mask), .in1_a_data(in1_a_data),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_opcode(in1_d_opcode),
    .in1_d_param(in1_d_param), .in1_d_size(in1_d_size), .in1_d_source(in1_d_source),
    .in1_d_denied(in1_d_denied), .in1_d_corrupt(in1_d_corrupt), .in1_d_data(in1_d_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_denied(out_d_denied), .out_d_corrupt(out_d_corrupt), .out_d_data(out_d_data)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    in0_a_opcode = OP_GET; in0_a_param = 3'd0; in0_a_size = 2'd2; in0_a_source = 2'd1;
    in0_a_address = 32'h100; in0_a_mask = 4'hf; in0_a_data = 32'h0;
    in1_a_opcode = OP_GET; in1_a_param = 3'd0; in1_a_size = 2'd2; in1_a_source = 2'd2;
    in1_a_address = 32'h200; in1_a_mask = 4'hf; in1_a_data = 32'h0;
    out_d_opcode = OP_ACK_DATA; out_d_param = 2'd0; out_d_size = 2'd2;
    out_d_denied = 1'b0; out_d_corrupt = 1'b0; out_d_data = 32'h0;
    in0_a_valid = 1'b1; in1_a_valid = 1'b1; out_a_ready = 1'b1;
    out_d_valid = 1'b1; out_d_source = 3'b000; in0_d_ready = 1'b1; in1_d_ready = 1'b1;
    tick;
    tick;
    #1;
    chk("rst_out_a_valid", out_a_valid, 0);
    chk("rst_in0_a_ready", in0_a_ready, 0);
    chk("rst_in1_a_ready", in1_a_ready, 0);
    chk("rst_in0_d_valid", in0_d_valid, 0);
    chk("rst_in1_d_valid", in1_d_valid, 0);
    chk("rst_out_d_ready", out_d_ready, 0);
    chk("rst_lock", dut.lock, 0);
    chk("rst_cnt0", dut.cnt0, 0);
    chk("rst_rr", dut.rr_ptr, 0);
    reset = 1'b0;
    out_d_valid = 1'b0;
    // back-to-back Gets from both masters alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt_src%0d", i), out_a_source, (i % 2) ? 3'b110 : 3'b001);
      chk($sformatf("alt_addr%0d", i), out_a_address, (i % 2) ? 32'h200 : 32'h100);
      chk($sformatf("alt_rdy0_%0d", i), in0_a_ready, (i % 2) ? 0 : 1);
      tick;
    end
    chk("alt_cnt0", dut.cnt0, 2);
    chk("alt_cnt1", dut.cnt1, 2);
    // same-cycle A fire and D fire for master 0
    in1_a_valid = 1'b0;
    out_d_valid = 1'b1; out_d_source = 3'b001;
    #1;
    chk("same_out_d_ready", out_d_ready, 1);
    chk("same_a_src", out_a_source, 3'b001);
    tick;
    chk("same_cnt0", dut.cnt0, 2);
    chk("same_rr", dut.rr_ptr, 1);
    in0_a_valid = 1'b0; out_a_ready = 1'b0;
    // D steering to master 1 with back-pressure
    out_d_source = 3'b101; out_d_data = 32'hdead_beef; in1_d_ready = 1'b0;
    #1;
    chk("d_in1_valid", in1_d_valid, 1);
    chk("d_in1_source", in1_d_source, 2'b01);
    chk("d_in0_valid", in0_d_valid, 0);
    chk("d_out_ready_hold", out_d_ready, 0);
    chk("d_fanout_data", in0_d_data, 32'hdead_beef);
    tick;
    chk("d_stall_cnt1", dut.cnt1, 2);
    in1_d_ready = 1'b1;
    #1;
    chk("d_out_ready", out_d_ready, 1);
    tick;
    chk("d_cnt1_dec", dut.cnt1, 1);
    out_d_source = 3'b110;
    tick;
    out_d_source = 3'b001;
    tick;
    tick;
    out_d_valid = 1'b0;
    #1;
    chk("drain_cnt0", dut.cnt0, 0);
    chk("drain_cnt1", dut.cnt1, 0);
    // master 0 stalled three cycles while master 1 arrives
    in0_a_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in1_a_valid = (k > 0);
      #1;
      chk($sformatf("stall_addr%0d", k), out_a_address, 32'h100);
      chk($sformatf("stall_src%0d", k), out_a_source, 3'b001);
      chk($sformatf("stall_rdy1_%0d", k), in1_a_ready, 0);
      tick;
    end
    chk("stall_lock", dut.lock, 1);
    out_a_ready = 1'b1;
    #1;
    chk("stall_fire_rdy0", in0_a_ready, 1);
    tick;
    in0_a_address = 32'h104;
    #1;
    chk("after_fire_addr", out_a_address, 32'h200);
    chk("after_fire_rdy1", in1_a_ready, 1);
    tick;
    in0_a_valid = 1'b0; in1_a_valid = 1'b0; out_a_ready = 1'b0;
    in0_a_address = 32'h100;
    out_d_valid = 1'b1; out_d_source = 3'b001;
    tick;
    out_d_source = 3'b110;
    tick;
    out_d_valid = 1'b0;
    chk("drain2_cnt0", dut.cnt0, 0);
    chk("drain2_cnt1", dut.cnt1, 0);
    // master 0 fills to MAX_OUT=4, master 1 still served
    in0_a_valid = 1'b1; out_a_ready = 1'b1;
    repeat (4) tick;
    #1;
    chk("max_cnt0", dut.cnt0, 4);
    chk("max_blocked_valid", out_a_valid, 0);
    chk("max_blocked_rdy0", in0_a_ready, 0);
    in1_a_valid = 1'b1;
    #1;
    chk("max_in1_src", out_a_source, 3'b110);
    chk("max_in1_rdy", in1_a_ready, 1);
    chk("max_in0_rdy", in0_a_ready, 0);
    tick;
    in1_a_valid = 1'b0;
    out_d_valid = 1'b1; out_d_source = 3'b001;
    #1;
    chk("max_still_blocked", out_a_valid, 0);
    tick;
    out_d_valid = 1'b0; out_a_ready = 1'b0;
    #1;
    chk("max_reelig_valid", out_a_valid, 1);
    chk("max_reelig_src", out_a_source, 3'b001);
    tick;
    chk("pre_rst_lock", dut.lock, 1);
    chk("pre_rst_cnt0", dut.cnt0, 3);
    // reset while locked
    reset = 1'b1;
    out_d_valid = 1'b1; out_d_source = 3'b001;
    #1;
    chk("mid_rst_a_valid", out_a_valid, 0);
    tick;
    chk("mid_rst_lock", dut.lock, 0);
    chk("mid_rst_cnt0", dut.cnt0, 0);
    chk("mid_rst_rr", dut.rr_ptr, 0);
    chk("mid_rst_d_valid", in0_d_valid, 0);
    chk("mid_rst_out_a_valid", out_a_valid, 0);
    reset = 1'b0;
    in0_a_valid = 1'b0; out_d_valid = 1'b0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
